// File: rtl/downstream_vc_manager_pkg.sv
// Shared NoC sizing parameters and the per-VC state encoding used by the
// downstream VC manager and its trackers.
package noc_params;
    localparam int PORT_NUM    = 5;
    localparam int VC_NUM      = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_state_t;
endpackage

// File: rtl/downstream_vc_manager_if.sv
// Allocation, flit-send and credit-return bundle between the router and the
// downstream VC manager.
interface downstream_vc_manager_if
    import noc_params::*;
#(
    parameter int PORT_NUM_P = noc_params::PORT_NUM,
    parameter int VC_NUM_P   = noc_params::VC_NUM,
    parameter int VC_SIZE_P  = (VC_NUM_P > 1) ? $clog2(VC_NUM_P) : 1
);
    logic [PORT_NUM_P-1:0]                   alloc_req_i;
    logic [PORT_NUM_P-1:0]                   alloc_gnt_o;
    logic [PORT_NUM_P-1:0][VC_SIZE_P-1:0]    alloc_vc_o;
    logic [PORT_NUM_P-1:0]                   flit_sent_i;
    logic [PORT_NUM_P-1:0][VC_SIZE_P-1:0]    flit_vc_i;
    logic [PORT_NUM_P-1:0]                   flit_tail_i;
    logic [PORT_NUM_P-1:0][VC_NUM_P-1:0]     credit_i;
    logic [PORT_NUM_P-1:0][VC_NUM_P-1:0]     credit_avail_o;
    logic [PORT_NUM_P-1:0][VC_NUM_P-1:0]     idle_vc_o;
    logic                                    err_o;

    modport master (
        output alloc_req_i, flit_sent_i, flit_vc_i, flit_tail_i, credit_i,
        input  alloc_gnt_o, alloc_vc_o, credit_avail_o, idle_vc_o, err_o
    );

    modport slave (
        input  alloc_req_i, flit_sent_i, flit_vc_i, flit_tail_i, credit_i,
        output alloc_gnt_o, alloc_vc_o, credit_avail_o, idle_vc_o, err_o
    );
endinterface

// File: rtl/downstream_vc_manager_tracker.sv
// One downstream VC: IDLE/ACTIVE/DRAIN lifecycle plus its credit counter.
// o_err is a single-cycle protocol-violation pulse; stickiness lives upstream.
module downstream_vc_tracker
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
)(
    input  logic clk,
    input  logic rst,
    input  logic i_grant,
    input  logic i_sent,
    input  logic i_tail,
    input  logic i_credit,
    output logic o_idle,
    output logic o_credit_avail,
    output logic o_err
);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

    vc_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= FULL;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_err       = 1'b0;
        w_state_nxt = r_state;
        // Counter saturates at both ends; an overrun or underrun flags an error.
        case ({i_sent, i_credit})
            2'b10: if (r_count == '0) w_err = 1'b1;
                   else               w_count_nxt = r_count - 1'b1;
            2'b01: if (r_count == FULL) w_err = 1'b1;
                   else                 w_count_nxt = r_count + 1'b1;
            2'b11: if (r_count == '0) w_err = 1'b1;
            default: ;
        endcase
        if (i_sent && (r_state != ACTIVE)) w_err = 1'b1;

        case (r_state)
            IDLE:    if (i_grant)            w_state_nxt = ACTIVE;
            ACTIVE:  if (i_sent && i_tail)   w_state_nxt = DRAIN;
            DRAIN:   if (w_count_nxt == FULL) w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    assign o_idle         = (r_state == IDLE);
    assign o_credit_avail = (r_count != '0);
    assign o_err          = w_err;
endmodule

// File: rtl/downstream_vc_manager.sv
// Tracks every downstream VC and hands out idle ones round-robin per port.
// Grant is combinational (0 cycles); status outputs are registered (1 cycle).
module downstream_vc_manager
    import noc_params::*;
#(
    parameter int PORT_NUM    = noc_params::PORT_NUM,
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
)(
    input  logic clk,
    input  logic rst,
    downstream_vc_manager_if.slave bus
);
    localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_NUM-1:0][VC_SIZE-1:0] r_rr_ptr;
    logic                             r_err;
    logic [PORT_NUM-1:0]              w_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0] w_gnt_vc;
    logic [PORT_NUM-1:0][VC_SIZE:0]   w_pick;
    logic [PORT_NUM-1:0][VC_NUM-1:0]  w_idle;
    logic [PORT_NUM-1:0][VC_NUM-1:0]  w_avail;
    logic [PORT_NUM-1:0][VC_NUM-1:0]  w_err_bits;

    // Returns {found, vc}: first idle VC starting one past the last grant.
    function automatic logic [VC_SIZE:0] rr_pick(input logic [VC_NUM-1:0] idle,
                                                 input logic [VC_SIZE-1:0] ptr);
        logic [VC_SIZE:0] pick;
        int               cand;
        pick = '0;
        for (int i = VC_NUM; i >= 1; i--) begin
            cand = (int'(ptr) + i) % VC_NUM;
            if (idle[cand]) pick = {1'b1, VC_SIZE'(cand)};
        end
        return pick;
    endfunction

    always_comb begin
        w_gnt    = '0;
        w_gnt_vc = '0;
        w_pick   = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_pick[p] = rr_pick(w_idle[p], r_rr_ptr[p]);
            if (bus.alloc_req_i[p] && w_pick[p][VC_SIZE]) begin
                w_gnt[p]    = 1'b1;
                w_gnt_vc[p] = w_pick[p][VC_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= {PORT_NUM{VC_SIZE'(VC_NUM - 1)}};
            r_err    <= 1'b0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (w_gnt[p]) r_rr_ptr[p] <= w_gnt_vc[p];
            end
            r_err <= r_err | (|w_err_bits);
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            downstream_vc_tracker #(
                .BUFFER_SIZE (BUFFER_SIZE)
            ) u_trk (
                .clk            (clk),
                .rst            (rst),
                .i_grant        (w_gnt[p] && (w_gnt_vc[p] == VC_SIZE'(v))),
                .i_sent         (bus.flit_sent_i[p] && (bus.flit_vc_i[p] == VC_SIZE'(v))),
                .i_tail         (bus.flit_tail_i[p]),
                .i_credit       (bus.credit_i[p][v]),
                .o_idle         (w_idle[p][v]),
                .o_credit_avail (w_avail[p][v]),
                .o_err          (w_err_bits[p][v])
            );
        end
    end

    assign bus.alloc_gnt_o    = w_gnt;
    assign bus.alloc_vc_o     = w_gnt_vc;
    assign bus.idle_vc_o      = w_idle;
    assign bus.credit_avail_o = w_avail;
    assign bus.err_o          = r_err;
endmodule

// File: tb/tb_downstream_vc_manager.sv
// Directed checks of allocation, credit accounting, draining and reset.
module tb_downstream_vc_manager;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    downstream_vc_manager_if ifc ();

    downstream_vc_manager dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        ifc.alloc_req_i = '0;
        ifc.flit_sent_i = '0;
        ifc.flit_vc_i   = '0;
        ifc.flit_tail_i = '0;
        ifc.credit_i    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_inputs();
        ifc.alloc_req_i = 5'b11111;
        #2;
        checks++;
        if (ifc.idle_vc_o !== 10'h3ff) begin
            failures++; $display("FAIL reset_idle got=%0h exp=3ff", ifc.idle_vc_o);
        end
        checks++;
        if (ifc.credit_avail_o !== 10'h3ff) begin
            failures++; $display("FAIL reset_avail got=%0h exp=3ff", ifc.credit_avail_o);
        end
        checks++;
        if (ifc.alloc_gnt_o !== 5'b11111) begin
            failures++; $display("FAIL reset_gnt got=%0h exp=1f", ifc.alloc_gnt_o);
        end
        checks++;
        if (ifc.alloc_vc_o !== 5'b00000) begin
            failures++; $display("FAIL reset_vc got=%0h exp=0", ifc.alloc_vc_o);
        end
        checks++;
        if (ifc.err_o !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%0b exp=0", ifc.err_o);
        end
        tick();
        tick();
        rst = 1'b0;
        ifc.alloc_req_i = '0;
    endtask

    task automatic test_alloc_rr();
        ifc.alloc_req_i = 5'b00001;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[0] !== 1'b1 || ifc.alloc_vc_o[0] !== 1'b0) begin
            failures++; $display("FAIL alloc_first got=%0b/%0b exp=1/0", ifc.alloc_gnt_o[0], ifc.alloc_vc_o[0]);
        end
        tick();
        checks++;
        if (ifc.alloc_gnt_o[0] !== 1'b1 || ifc.alloc_vc_o[0] !== 1'b1 || ifc.idle_vc_o[0] !== 2'b10) begin
            failures++; $display("FAIL alloc_second got=%0b/%0b/%0b exp=1/1/10",
                                 ifc.alloc_gnt_o[0], ifc.alloc_vc_o[0], ifc.idle_vc_o[0]);
        end
        tick();
        checks++;
        if (ifc.alloc_gnt_o[0] !== 1'b0 || ifc.alloc_vc_o[0] !== 1'b0 || ifc.idle_vc_o[0] !== 2'b00) begin
            failures++; $display("FAIL alloc_full got=%0b/%0b/%0b exp=0/0/00",
                                 ifc.alloc_gnt_o[0], ifc.alloc_vc_o[0], ifc.idle_vc_o[0]);
        end
        ifc.alloc_req_i = '0;
    endtask

    task automatic test_drain();
        ifc.alloc_req_i = 5'b00010;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[1] !== 1'b1 || ifc.alloc_vc_o[1] !== 1'b0) begin
            failures++; $display("FAIL drain_gnt got=%0b/%0b exp=1/0", ifc.alloc_gnt_o[1], ifc.alloc_vc_o[1]);
        end
        tick();
        ifc.alloc_req_i = '0;
        for (int i = 0; i < 8; i++) begin
            ifc.flit_sent_i[1] = 1'b1;
            ifc.flit_vc_i[1]   = 1'b0;
            ifc.flit_tail_i[1] = (i == 7);
            tick();
        end
        clr_inputs();
        checks++;
        if (ifc.credit_avail_o[1][0] !== 1'b0 || ifc.idle_vc_o[1][0] !== 1'b0 || ifc.err_o !== 1'b0) begin
            failures++; $display("FAIL drain_empty got=%0b/%0b/%0b exp=0/0/0",
                                 ifc.credit_avail_o[1][0], ifc.idle_vc_o[1][0], ifc.err_o);
        end
        for (int i = 0; i < 8; i++) begin
            ifc.credit_i[1][0] = 1'b1;
            #1;
            checks++;
            if (ifc.idle_vc_o[1][0] !== 1'b0) begin
                failures++; $display("FAIL drain_early_idle credit=%0d got=1 exp=0", i);
            end
            tick();
        end
        clr_inputs();
        checks++;
        if (ifc.idle_vc_o[1][0] !== 1'b1 || ifc.credit_avail_o[1][0] !== 1'b1) begin
            failures++; $display("FAIL drain_idle got=%0b/%0b exp=1/1",
                                 ifc.idle_vc_o[1][0], ifc.credit_avail_o[1][0]);
        end
    endtask

    task automatic test_send_credit_same();
        ifc.alloc_req_i = 5'b00100;
        tick();
        ifc.alloc_req_i = '0;
        for (int i = 0; i < 5; i++) begin
            ifc.flit_sent_i[2] = 1'b1;
            tick();
        end
        ifc.credit_i[2][0] = 1'b1;
        tick();
        ifc.credit_i[2][0] = 1'b0;
        ifc.flit_tail_i[2] = 1'b1;
        tick();
        clr_inputs();
        // 8 - 5 sends = 3, unchanged by the paired cycle, tail leaves 2: six credits to refill
        for (int i = 0; i < 6; i++) begin
            ifc.credit_i[2][0] = 1'b1;
            #1;
            checks++;
            if (ifc.idle_vc_o[2][0] !== 1'b0) begin
                failures++; $display("FAIL same_early_idle credit=%0d got=1 exp=0", i);
            end
            tick();
        end
        clr_inputs();
        checks++;
        if (ifc.idle_vc_o[2][0] !== 1'b1 || ifc.err_o !== 1'b0) begin
            failures++; $display("FAIL same_refill got=%0b/%0b exp=1/0", ifc.idle_vc_o[2][0], ifc.err_o);
        end
    endtask

    task automatic test_rr_free();
        ifc.alloc_req_i = 5'b01000;
        tick();
        tick();
        ifc.alloc_req_i = '0;
        ifc.flit_sent_i[3] = 1'b1;
        ifc.flit_vc_i[3]   = 1'b1;
        ifc.flit_tail_i[3] = 1'b1;
        tick();
        clr_inputs();
        ifc.credit_i[3][1] = 1'b1;
        tick();
        clr_inputs();
        checks++;
        if (ifc.idle_vc_o[3] !== 2'b10) begin
            failures++; $display("FAIL rr_vc1_free got=%0b exp=10", ifc.idle_vc_o[3]);
        end
        ifc.alloc_req_i = 5'b01000;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[3] !== 1'b1 || ifc.alloc_vc_o[3] !== 1'b1) begin
            failures++; $display("FAIL rr_regrant_vc1 got=%0b/%0b exp=1/1", ifc.alloc_gnt_o[3], ifc.alloc_vc_o[3]);
        end
        tick();
        ifc.alloc_req_i = '0;
        ifc.flit_sent_i[3] = 1'b1;
        ifc.flit_vc_i[3]   = 1'b0;
        ifc.flit_tail_i[3] = 1'b1;
        tick();
        clr_inputs();
        ifc.credit_i[3][0] = 1'b1;
        tick();
        clr_inputs();
        ifc.alloc_req_i = 5'b01000;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[3] !== 1'b1 || ifc.alloc_vc_o[3] !== 1'b0 || ifc.idle_vc_o[3] !== 2'b01) begin
            failures++; $display("FAIL rr_grant_vc0 got=%0b/%0b/%0b exp=1/0/01",
                                 ifc.alloc_gnt_o[3], ifc.alloc_vc_o[3], ifc.idle_vc_o[3]);
        end
        tick();
        ifc.alloc_req_i = '0;
    endtask

    task automatic test_credit_overflow();
        ifc.credit_i[4][1] = 1'b1;
        tick();
        clr_inputs();
        checks++;
        if (ifc.err_o !== 1'b1 || ifc.credit_avail_o[4][1] !== 1'b1 || ifc.idle_vc_o[4][1] !== 1'b1) begin
            failures++; $display("FAIL ovf_err got=%0b/%0b/%0b exp=1/1/1",
                                 ifc.err_o, ifc.credit_avail_o[4][1], ifc.idle_vc_o[4][1]);
        end
        ifc.alloc_req_i = 5'b10000;
        tick();
        tick();
        ifc.alloc_req_i = '0;
        ifc.flit_sent_i[4] = 1'b1;
        ifc.flit_vc_i[4]   = 1'b1;
        ifc.flit_tail_i[4] = 1'b1;
        tick();
        clr_inputs();
        ifc.credit_i[4][1] = 1'b1;
        tick();
        clr_inputs();
        checks++;
        if (ifc.idle_vc_o[4] !== 2'b10 || ifc.err_o !== 1'b1) begin
            failures++; $display("FAIL ovf_saturate got=%0b/%0b exp=10/1", ifc.idle_vc_o[4], ifc.err_o);
        end
    endtask

    task automatic test_async_reset();
        ifc.alloc_req_i = 5'b00010;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[1] !== 1'b1 || ifc.alloc_vc_o[1] !== 1'b1) begin
            failures++; $display("FAIL mid_gnt got=%0b/%0b exp=1/1", ifc.alloc_gnt_o[1], ifc.alloc_vc_o[1]);
        end
        tick();
        ifc.alloc_req_i = '0;
        ifc.flit_sent_i[1] = 1'b1;
        ifc.flit_vc_i[1]   = 1'b1;
        tick();
        clr_inputs();
        #2;
        rst = 1'b1;
        ifc.alloc_req_i = 5'b10101;
        #1;
        checks++;
        if (ifc.idle_vc_o !== 10'h3ff || ifc.credit_avail_o !== 10'h3ff) begin
            failures++; $display("FAIL async_state got=%0h/%0h exp=3ff/3ff", ifc.idle_vc_o, ifc.credit_avail_o);
        end
        checks++;
        if (ifc.err_o !== 1'b0 || ifc.alloc_gnt_o !== 5'b10101 || ifc.alloc_vc_o !== 5'b00000) begin
            failures++; $display("FAIL async_out got=%0b/%0h/%0h exp=0/15/0",
                                 ifc.err_o, ifc.alloc_gnt_o, ifc.alloc_vc_o);
        end
        tick();
        rst = 1'b0;
        ifc.alloc_req_i = 5'b00001;
        #1;
        checks++;
        if (ifc.alloc_gnt_o[0] !== 1'b1 || ifc.alloc_vc_o[0] !== 1'b0) begin
            failures++; $display("FAIL post_reset_gnt got=%0b/%0b exp=1/0", ifc.alloc_gnt_o[0], ifc.alloc_vc_o[0]);
        end
        tick();
        ifc.alloc_req_i = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alloc_rr();
        test_drain();
        test_send_credit_same();
        test_rr_free();
        test_credit_overflow();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/downstream_vc_manager.md
DOWNSTREAM_VC_MANAGER -- requirements
Module: downstream_vc_manager

Interface
REQ-001 Parameter PORT_NUM, default noc_params::PORT_NUM (5), number of downstream ports tracked.
REQ-002 Parameter VC_NUM, default noc_params::VC_NUM (2), VCs per downstream input port.
REQ-003 Parameter BUFFER_SIZE, default noc_params::BUFFER_SIZE (8), flit slots per downstream VC buffer.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 alloc_req_i  input  [PORT_NUM]  request to allocate one downstream VC on that port this cycle.
REQ-007 alloc_gnt_o  output  [PORT_NUM]  allocation granted this cycle (combinational).
REQ-008 alloc_vc_o  output  [PORT_NUM][VC_SIZE]  granted downstream VC index; valid only with alloc_gnt_o.
REQ-009 flit_sent_i  input  [PORT_NUM]  one flit forwarded downstream on that port this cycle.
REQ-010 flit_vc_i  input  [PORT_NUM][VC_SIZE]  downstream VC of the sent flit.
REQ-011 flit_tail_i  input  [PORT_NUM]  sent flit is a tail (or head-tail) flit.
REQ-012 credit_i  input  [PORT_NUM][VC_NUM]  one credit returned per asserted bit.
REQ-013 credit_avail_o  output  [PORT_NUM][VC_NUM]  credit counter nonzero (registered state).
REQ-014 idle_vc_o  output  [PORT_NUM][VC_NUM]  VC in IDLE; drives the VC allocator idle_downstream_vc_i.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Each (port,vc) SHALL hold a 3-state FSM IDLE/ACTIVE/DRAIN and a credit counter of width $clog2(BUFFER_SIZE+1).
REQ-017 IDLE->ACTIVE on the edge following a grant of that VC; ACTIVE->DRAIN on the edge where flit_sent_i & flit_tail_i target it; DRAIN->IDLE on the edge where the next counter value equals BUFFER_SIZE.
REQ-018 A tail sent while the counter will be BUFFER_SIZE after update (impossible in legal traffic) SHALL go ACTIVE->DRAIN, then IDLE one cycle later.
REQ-019 Grant per port: if alloc_req_i and at least one IDLE VC, alloc_gnt_o=1 and alloc_vc_o = first IDLE VC at or after rr_ptr+1 (mod VC_NUM); else alloc_gnt_o=0, alloc_vc_o=0.
REQ-020 Per-port rr_ptr SHALL update to the granted VC on each grant; unchanged otherwise.
REQ-021 Counter next = count - sent + credit, each term 0 or 1; simultaneous send and credit on the same VC SHALL leave it unchanged.
REQ-022 Credit into a counter at BUFFER_SIZE with no send SHALL saturate and set err_o.
REQ-023 Send to a VC with counter 0, or to a VC not ACTIVE, SHALL set err_o; counter saturates at 0, FSM unaffected by the non-ACTIVE send.
REQ-024 err_o SHALL stay 1 until reset.
REQ-025 Grant latency 0 cycles; idle_vc_o deasserts one cycle after grant; credit_avail_o reflects updates one cycle later.

Reset
REQ-026 On rst: all FSMs IDLE, all counters BUFFER_SIZE, rr_ptr = VC_NUM-1 (first grant picks VC 0), err_o=0.
REQ-027 Reset outputs: idle_vc_o all 1, credit_avail_o all 1, alloc_gnt_o = alloc_req_i (all VCs idle), alloc_vc_o 0.
REQ-028 rst mid-operation SHALL discard in-flight state immediately, regardless of clk.

Structure
REQ-029 PORT_NUM, VC_NUM, VC_SIZE, BUFFER_SIZE and a vc_state_t enum (IDLE/ACTIVE/DRAIN) SHALL live in noc_params.
REQ-030 One sub-module downstream_vc_tracker (single VC FSM + counter + error bits), instantiated PORT_NUM*VC_NUM times; round-robin select stays in the top level.

Verification
REQ-031 Reset, alloc_req_i[0]=1 two cycles -> gnt VC0 then VC1; third cycle gnt=0; idle_vc_o[0]=2'b00.
REQ-032 VC0 port1: 8 sends, tail on 8th -> credit_avail_o[1][0]=0, DRAIN; 8 credits -> IDLE exactly on edge of 8th credit, idle_vc_o[1][0]=1.
REQ-033 Same-cycle send and credit on counter=3 -> counter stays 3, err_o=0.
REQ-034 Credit to VC at 8 with no send -> counter 8, err_o=1 and stays 1.
REQ-035 VC1 freed while VC0 busy, rr_ptr=1 -> next request grants VC1 not skipped; then VC0 freed -> next grant VC0.
REQ-036 rst asserted mid-packet between clk edges -> outputs return to reset values before next edge.
